// File: rtl/reg_alu_inputs_if.sv
// reg_alu_inputs_if: operand-load strobes/buses in, registered operands and status out
interface reg_alu_inputs_if #(parameter int WIDTH = 8);
    logic             zero_load;
    logic             sb_load;
    logic [WIDTH-1:0] sb_data;
    logic             db_load;
    logic             db_inv_load;
    logic             adl_load;
    logic [WIDTH-1:0] db_data;
    logic [WIDTH-1:0] adl_data;
    logic             consume;
    logic             clr_conflict;
    logic [WIDTH-1:0] a_out;
    logic [WIDTH-1:0] b_out;
    logic             a_valid;
    logic             b_valid;
    logic             ops_ready;
    logic             conflict;
    modport master (
        output zero_load, sb_load, sb_data, db_load, db_inv_load, adl_load,
               db_data, adl_data, consume, clr_conflict,
        input  a_out, b_out, a_valid, b_valid, ops_ready, conflict
    );
    modport slave (
        input  zero_load, sb_load, sb_data, db_load, db_inv_load, adl_load,
               db_data, adl_data, consume, clr_conflict,
        output a_out, b_out, a_valid, b_valid, ops_ready, conflict
    );
endinterface

// File: rtl/reg_alu_inputs.sv
// reg_alu_inputs: ALU A/B operand registers with freshness FSM and sticky multi-source conflict flag
module reg_alu_inputs #(parameter int WIDTH = 8) (
    input logic             clk,
    input logic             rst_n,
    reg_alu_inputs_if.slave bus
);
    // state bit 0 = A fresh, bit 1 = B fresh, so next state is just the two valid bits
    typedef enum logic [1:0] {EMPTY = 2'b00, HALF_A = 2'b01, HALF_B = 2'b10, FULL = 2'b11} state_t;
    state_t           state, state_n;
    logic [WIDTH-1:0] a_q, b_q, a_n, b_n;
    logic             conflict_q, conflict_n;
    logic             a_ld, b_ld, a_v, b_v;
    // operand registers, occupancy state and conflict flag; reset discards everything at once
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= EMPTY;
            a_q        <= '0;
            b_q        <= '0;
            conflict_q <= 1'b0;
        end else begin
            state      <= state_n;
            a_q        <= a_n;
            b_q        <= b_n;
            conflict_q <= conflict_n;
        end
    end
    // source selection by priority, next occupancy (a load beats a same-edge consume), conflict set-over-clear
    always_comb begin
        a_ld       = bus.zero_load | bus.sb_load;
        b_ld       = bus.db_inv_load | bus.db_load | bus.adl_load;
        a_v        = (state == HALF_A) || (state == FULL);
        b_v        = (state == HALF_B) || (state == FULL);
        a_n        = bus.zero_load ? '0 : bus.sb_load ? bus.sb_data : a_q;
        b_n        = bus.db_inv_load ? ~bus.db_data : bus.db_load ? bus.db_data :
                     bus.adl_load ? bus.adl_data : b_q;
        state_n    = state_t'({b_ld | (b_v & ~bus.consume), a_ld | (a_v & ~bus.consume)});
        conflict_n = (bus.zero_load & bus.sb_load) |
                     (bus.db_inv_load & bus.db_load) | (bus.db_inv_load & bus.adl_load) |
                     (bus.db_load & bus.adl_load) | (conflict_q & ~bus.clr_conflict);
    end
    assign bus.a_out     = a_q;
    assign bus.b_out     = b_q;
    assign bus.a_valid   = (state == HALF_A) || (state == FULL);
    assign bus.b_valid   = (state == HALF_B) || (state == FULL);
    assign bus.ops_ready = (state == FULL);
    assign bus.conflict  = conflict_q;
endmodule
